com_link_tx_sched: RTL and testbench

//  Transmit-side scheduler for the 6-bit PSX<->DE2-115 com link (com_channel/com_clk/com_req).

---
 rtl/psx_com_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/com_link_tx_sched.sv | 140 ++++++++++++++
 tb/tb_com_link_tx_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_com_pkg.sv
// Shared types and helpers for the PSX <-> DE2-115 6-bit com link transmitter.
package psx_com_pkg;

  localparam int BEAT_W  = 6;
  localparam int N_BEATS = 6;
  localparam int FRAME_W = 36;

  typedef enum logic [1:0] {
    IDLE,
    BEAT_LO,
    BEAT_HI,
    GAP
  } tx_state_t;

  // Frame layout: {src_id, even parity of data, reserved zero, data}.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [1:0] src, input logic [31:0] data);
    return {src, ^data, 1'b0, data};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] valid_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] grant_o,
  output logic [1:0]   idx_o,
  output logic         any_o
);

  logic [1:0] cand;

  // Scan requesters starting at ptr and wrapping, keep the first valid one.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = 2'((int'(ptr_i) + i) % N);
      if (!any_o && valid_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_link_tx_sched.sv
// Transmit scheduler for the 6-bit com link: picks one requester word round-robin,
// packs it into a 36-bit frame and sends it as six 6-bit beats with a generated com_clk.
module com_link_tx_sched
  import psx_com_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int HALF_PER = 4,
  parameter int GAP_CYC  = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*32-1:0] req_data_i,
  output logic [N_REQ-1:0]    req_ack_o,
  output logic [BEAT_W-1:0]   com_channel_o,
  output logic                com_clk_o,
  output logic                com_req_o,
  output logic                busy_o,
  output logic [15:0]         frame_cnt_o
);

  localparam int MAX_CNT = (HALF_PER > GAP_CYC) ? HALF_PER : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PER - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [2:0]       BEAT_LAST = 3'(N_BEATS - 1);

  tx_state_t                   state_q;
  logic [CNT_W-1:0]            phase_q;
  logic [2:0]                  beat_q;
  logic [FRAME_W-BEAT_W-1:0]   shift_q;
  logic [BEAT_W-1:0]           channel_q;
  logic                        comClk_q;
  logic                        comReq_q;
  logic [N_REQ-1:0]            ack_q;
  logic [15:0]                 frameCnt_q;
  logic [1:0]                  rrPtr_q;

  logic [FRAME_W-1:0]          frame_d;
  logic [1:0]                  rrPtr_d;

  logic [N_REQ-1:0]            grantOh;
  logic [1:0]                  grantIdx;
  logic                        anyValid;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (rrPtr_q),
    .grant_o (grantOh),
    .idx_o   (grantIdx),
    .any_o   (anyValid)
  );

  // Build the candidate frame for the current winner and the pointer that follows it.
  always_comb begin
    frame_d = pack_frame(grantIdx, req_data_i[{grantIdx, 5'd0} +: 32]);
    rrPtr_d = (int'(grantIdx) == N_REQ - 1) ? 2'd0 : grantIdx + 2'd1;
  end

  // Frame sequencer: grant in IDLE, then six low/high beat phases, then the inter-frame gap.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      beat_q     <= '0;
      shift_q    <= '0;
      channel_q  <= '0;
      comClk_q   <= 1'b0;
      comReq_q   <= 1'b0;
      ack_q      <= '0;
      frameCnt_q <= '0;
      rrPtr_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (anyValid) begin
            ack_q     <= grantOh;
            channel_q <= frame_d[BEAT_W-1:0];
            shift_q   <= frame_d[FRAME_W-1:BEAT_W];
            comReq_q  <= 1'b1;
            comClk_q  <= 1'b0;
            beat_q    <= '0;
            phase_q   <= '0;
            rrPtr_q   <= rrPtr_d;
            state_q   <= BEAT_LO;
          end
        end
        BEAT_LO: begin
          if (phase_q == HALF_LAST) begin
            phase_q  <= '0;
            comClk_q <= 1'b1;
            state_q  <= BEAT_HI;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        BEAT_HI: begin
          if (phase_q == HALF_LAST) begin
            phase_q  <= '0;
            comClk_q <= 1'b0;
            if (beat_q == BEAT_LAST) begin
              comReq_q   <= 1'b0;
              channel_q  <= '0;
              frameCnt_q <= frameCnt_q + 16'd1;
              state_q    <= GAP;
            end else begin
              beat_q    <= beat_q + 3'd1;
              channel_q <= shift_q[BEAT_W-1:0];
              shift_q   <= shift_q >> BEAT_W;
              state_q   <= BEAT_LO;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        GAP: begin
          if (phase_q == GAP_LAST) begin
            phase_q <= '0;
            state_q <= IDLE;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack_o     = ack_q;
  assign com_channel_o = channel_q;
  assign com_clk_o     = comClk_q;
  assign com_req_o     = comReq_q;
  assign busy_o        = (state_q != IDLE);
  assign frame_cnt_o   = frameCnt_q;

endmodule

// File: tb/tb_com_link_tx_sched.sv
// Self-checking bench for com_link_tx_sched: frames are captured off the link pins and
// compared against frames built from the link rules (round-robin winner, packed word, beat timing).
module tb_com_link_tx_sched;

  localparam int HP_A  = 2;
  localparam int GAP_A = 8;
  localparam int HP_B  = 1;
  localparam int GAP_B = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   validA = '0;
  logic [3:0]   validB = '0;
  logic [127:0] dataA = '0;
  logic [127:0] dataB = '0;
  logic [3:0]   ackA, ackB;
  logic [5:0]   chA, chB;
  logic         clkA, clkB, reqA, reqB, busyA, busyB;
  logic [15:0]  cntA, cntB;

  int testsRun = 0;
  int failCount = 0;
  int modelPtr = 0;
  int modelCnt = 0;

  // Link timing watchdog state for the main instance.
  int   chanViol = 0, riseViol = 0, gapViol = 0, lenViol = 0, framesSeen = 0;
  int   rises = 0, highCnt = 0, lowCnt = 0;
  bit   seenFrame = 1'b0;
  logic prevClk = 1'b0, prevReq = 1'b0;
  logic [5:0] prevCh = '0;

  always #5 clk = ~clk;

  com_link_tx_sched #(.N_REQ(4), .HALF_PER(HP_A), .GAP_CYC(GAP_A)) dutA (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(validA), .req_data_i(dataA),
    .req_ack_o(ackA), .com_channel_o(chA), .com_clk_o(clkA), .com_req_o(reqA),
    .busy_o(busyA), .frame_cnt_o(cntA)
  );

  com_link_tx_sched #(.N_REQ(4), .HALF_PER(HP_B), .GAP_CYC(GAP_B)) dutB (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(validB), .req_data_i(dataB),
    .req_ack_o(ackB), .com_channel_o(chB), .com_clk_o(clkB), .com_req_o(reqB),
    .busy_o(busyB), .frame_cnt_o(cntB)
  );

  // Continuous pin-level watchdog: channel stable while com_clk high, 6 rises and
  // 12*HALF_PER high cycles per com_req pulse, at least GAP_CYC low cycles between frames.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevClk = 1'b0; prevReq = 1'b0; prevCh = '0;
      rises = 0; highCnt = 0; lowCnt = 0; seenFrame = 1'b0;
    end else begin
      if (prevClk && clkA && chA !== prevCh) chanViol++;
      if (reqA) begin
        highCnt++;
        if (clkA && !prevClk) rises++;
      end
      if (prevReq && !reqA) begin
        framesSeen++;
        if (rises != 6) riseViol++;
        if (highCnt != 12 * HP_A) lenViol++;
        rises = 0; highCnt = 0; lowCnt = 0; seenFrame = 1'b1;
      end
      if (!prevReq && reqA && seenFrame && lowCnt < GAP_A) gapViol++;
      if (!reqA) lowCnt++;
      prevClk = clkA; prevReq = reqA; prevCh = chA;
    end
  end

  function automatic int pickWinner(input logic [3:0] v, input int ptr);
    for (int i = 0; i < 4; i++) begin
      if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [35:0] expFrame(input int src, input logic [31:0] d);
    logic [1:0] s;
    s = 2'(src);
    return {s, ^d, 1'b0, d};
  endfunction

  // Waits for an ack on the main instance, then records beats on every com_clk rise until com_req falls.
  task automatic capture(output logic [3:0] ack, output logic [35:0] word, output int nbeats,
                         output int reqLen, output int extraAcks, output bit ok);
    logic pc;
    ok = 1'b0; word = '0; nbeats = 0; reqLen = 0; extraAcks = 0; ack = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ackA != 4'b0) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    ack = ackA;
    reqLen = reqA ? 1 : 0;
    pc = clkA;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!reqA) begin ok = 1'b1; break; end
      reqLen++;
      if (ackA != 4'b0) extraAcks++;
      if (clkA && !pc) begin
        if (nbeats < 6) word[6*nbeats +: 6] = chA;
        nbeats++;
      end
      pc = clkA;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; validA = '0; validB = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelPtr = 0; modelCnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({ackA, chA, clkA, reqA, busyA} !== 13'b0) begin
      failCount++; $display("[TB] FAIL reset_outputs_a: got %h expected 0", {ackA, chA, clkA, reqA, busyA});
    end
    testsRun++;
    if (cntA !== 16'h0000) begin
      failCount++; $display("[TB] FAIL reset_frame_cnt: got %h expected 0000", cntA);
    end
    testsRun++;
    if ({ackB, chB, clkB, reqB, busyB, cntB} !== 29'b0) begin
      failCount++; $display("[TB] FAIL reset_outputs_b: got %h expected 0", {ackB, chB, clkB, reqB, busyB, cntB});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (busyA !== 1'b0 || reqA !== 1'b0) begin
      failCount++; $display("[TB] FAIL idle_after_reset: got busy=%b req=%b expected 0 0", busyA, reqA);
    end
    modelPtr = 0; modelCnt = 0;
  endtask

  task automatic test_single_word();
    logic [3:0] ack; logic [35:0] word; int nb, len, extra; bit ok;
    dataA = {$urandom, $urandom, $urandom, $urandom};
    dataA[95:64] = 32'hDEADBEEF;
    validA = 4'b0100;
    capture(ack, word, nb, len, extra, ok);
    validA = '0;
    testsRun++;
    if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL single_timeout: got ok=%b expected 1", ok); end
    testsRun++;
    if (ack !== 4'b0100) begin failCount++; $display("[TB] FAIL single_ack: got %b expected 0100", ack); end
    testsRun++;
    if (word !== 36'h8DEADBEEF) begin failCount++; $display("[TB] FAIL single_beats: got %h expected 8deadbeef", word); end
    testsRun++;
    if (nb != 6 || len != 12 * HP_A || extra != 0) begin
      failCount++; $display("[TB] FAIL single_shape: got beats=%0d len=%0d extra_acks=%0d expected 6 %0d 0", nb, len, extra, 12 * HP_A);
    end
    testsRun++;
    if (cntA !== 16'd1) begin failCount++; $display("[TB] FAIL single_frame_cnt: got %0d expected 1", cntA); end
    modelPtr = 3; modelCnt = 1;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] ack; logic [35:0] word; int nb, len, extra; bit ok;
    do_reset();
    dataA = {$urandom, $urandom, $urandom, $urandom};
    validA = 4'hF;
    for (int k = 0; k < 5; k++) begin
      capture(ack, word, nb, len, extra, ok);
      testsRun++;
      if (ok !== 1'b1 || ack !== 4'(1 << order[k])) begin
        failCount++; $display("[TB] FAIL rr_ack_%0d: got %b ok=%b expected %b", k, ack, ok, 4'(1 << order[k]));
      end
      testsRun++;
      if (word !== expFrame(order[k], dataA[32*order[k] +: 32])) begin
        failCount++; $display("[TB] FAIL rr_frame_%0d: got %h expected %h", k, word, expFrame(order[k], dataA[32*order[k] +: 32]));
      end
      dataA[32*order[k] +: 32] = $urandom;
    end
    validA = '0;
    modelPtr = 1; modelCnt = 5;
    testsRun++;
    if (cntA !== 16'd5) begin failCount++; $display("[TB] FAIL rr_frame_cnt: got %0d expected 5", cntA); end
  endtask

  task automatic test_random();
    logic [3:0] ack; logic [35:0] word; int nb, len, extra, g; bit ok;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      dataA = {$urandom, $urandom, $urandom, $urandom};
      validA = 4'($urandom_range(1, 15));
      g = pickWinner(validA, modelPtr);
      capture(ack, word, nb, len, extra, ok);
      validA = '0;
      modelPtr = (g + 1) % 4;
      modelCnt++;
      testsRun++;
      if (ok !== 1'b1 || ack !== 4'(1 << g)) begin
        failCount++; $display("[TB] FAIL rand_ack_%0d: got %b ok=%b expected %b", k, ack, ok, 4'(1 << g));
      end
      testsRun++;
      if (word !== expFrame(g, dataA[32*g +: 32]) || nb != 6) begin
        failCount++; $display("[TB] FAIL rand_frame_%0d: got %h beats=%0d expected %h beats=6", k, word, nb, expFrame(g, dataA[32*g +: 32]));
      end
      testsRun++;
      if (cntA !== 16'(modelCnt)) begin
        failCount++; $display("[TB] FAIL rand_frame_cnt_%0d: got %0d expected %0d", k, cntA, modelCnt);
      end
    end
  endtask

  task automatic test_valid_drop();
    logic [3:0] ack; logic [35:0] word; int nb, len, extra, acks, highs; bit ok;
    dataA = {$urandom, $urandom, $urandom, $urandom};
    validA = 4'b0001;
    capture(ack, word, nb, len, extra, ok);
    validA = 4'b0010;
    modelPtr = 1; modelCnt++;
    @(negedge clk);
    validA = '0;
    acks = 0; highs = 0;
    if (ackA != 4'b0) acks++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ackA != 4'b0) acks++;
      if (reqA) highs++;
    end
    testsRun++;
    if (ok !== 1'b1 || ack !== 4'b0001) begin
      failCount++; $display("[TB] FAIL drop_setup_ack: got %b ok=%b expected 0001", ack, ok);
    end
    testsRun++;
    if (acks != 0 || highs != 0) begin
      failCount++; $display("[TB] FAIL drop_never_acked: got acks=%0d req_high=%0d expected 0 0", acks, highs);
    end
    testsRun++;
    if (cntA !== 16'(modelCnt)) begin
      failCount++; $display("[TB] FAIL drop_frame_cnt: got %0d expected %0d", cntA, modelCnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] ack; logic [35:0] word; int nb, len, extra, seen; bit ok; logic pc;
    dataA = {$urandom, $urandom, $urandom, $urandom};
    validA = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ackA != 4'b0) begin ok = 1'b1; break; end
    end
    seen = 0; pc = clkA;
    for (int i = 0; i < 300 && ok && seen < 4; i++) begin
      @(negedge clk);
      if (clkA && !pc) seen++;
      pc = clkA;
    end
    testsRun++;
    if (ok !== 1'b1 || seen != 4) begin
      failCount++; $display("[TB] FAIL midrst_reach_beat3: got ok=%b rises=%0d expected 1 4", ok, seen);
    end
    rst_n = 1'b0;
    @(negedge clk);
    validA = '0;
    testsRun++;
    if ({reqA, clkA, busyA, ackA} !== 7'b0) begin
      failCount++; $display("[TB] FAIL midrst_abort: got req=%b clk=%b busy=%b ack=%b expected all 0", reqA, clkA, busyA, ackA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelPtr = 0; modelCnt = 0;
    testsRun++;
    if (cntA !== 16'd0) begin failCount++; $display("[TB] FAIL midrst_frame_cnt: got %0d expected 0", cntA); end
    validA = 4'b1000;
    capture(ack, word, nb, len, extra, ok);
    validA = '0;
    modelPtr = 0; modelCnt = 1;
    testsRun++;
    if (ok !== 1'b1 || ack !== 4'b1000) begin
      failCount++; $display("[TB] FAIL midrst_restart_ack: got %b ok=%b expected 1000", ack, ok);
    end
    testsRun++;
    if (word !== expFrame(3, dataA[127:96]) || nb != 6 || len != 12 * HP_A) begin
      failCount++; $display("[TB] FAIL midrst_restart_frame: got %h beats=%0d len=%0d expected %h 6 %0d", word, nb, len, expFrame(3, dataA[127:96]), 12 * HP_A);
    end
    testsRun++;
    if (cntA !== 16'd1) begin failCount++; $display("[TB] FAIL midrst_count_after: got %0d expected 1", cntA); end
  endtask

  task automatic test_wrap();
    logic [3:0] ack; logic [35:0] word; int nb, len, extra; bit ok;
    repeat (GAP_A + 4) @(negedge clk);
    force dutA.frameCnt_q = 16'hFFFF;
    #1;
    release dutA.frameCnt_q;
    #1;
    testsRun++;
    if (cntA !== 16'hFFFF) begin failCount++; $display("[TB] FAIL wrap_preload: got %h expected ffff", cntA); end
    dataA = {$urandom, $urandom, $urandom, $urandom};
    validA = 4'b0100;
    capture(ack, word, nb, len, extra, ok);
    validA = '0;
    modelPtr = 3; modelCnt = 0;
    testsRun++;
    if (ok !== 1'b1 || cntA !== 16'h0000) begin
      failCount++; $display("[TB] FAIL wrap_frame_cnt: got %h ok=%b expected 0000", cntA, ok);
    end
  endtask

  task automatic test_half_per_one();
    int highs, rs; bit ok; logic pc; logic [3:0] ack;
    dataB = {$urandom, $urandom, $urandom, $urandom};
    validB = 4'b0001;
    ok = 1'b0; ack = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ackB != 4'b0) begin ok = 1'b1; ack = ackB; break; end
    end
    highs = reqB ? 1 : 0; rs = 0; pc = clkB;
    for (int i = 0; i < 300 && ok; i++) begin
      @(negedge clk);
      if (!reqB) break;
      highs++;
      if (clkB && !pc) rs++;
      pc = clkB;
    end
    validB = '0;
    testsRun++;
    if (ok !== 1'b1 || ack !== 4'b0001) begin
      failCount++; $display("[TB] FAIL hp1_ack: got %b ok=%b expected 0001", ack, ok);
    end
    testsRun++;
    if (highs != 12 * HP_B || rs != 6) begin
      failCount++; $display("[TB] FAIL hp1_req_len: got len=%0d rises=%0d expected %0d 6", highs, rs, 12 * HP_B);
    end
    testsRun++;
    if (cntB !== 16'd1) begin failCount++; $display("[TB] FAIL hp1_frame_cnt: got %0d expected 1", cntB); end
  endtask

  task automatic test_timing();
    repeat (GAP_A + 2) @(negedge clk);
    testsRun++;
    if (chanViol != 0) begin failCount++; $display("[TB] FAIL timing_channel_stable: got %0d changes expected 0", chanViol); end
    testsRun++;
    if (riseViol != 0 || lenViol != 0) begin
      failCount++; $display("[TB] FAIL timing_frame_shape: got rise_err=%0d len_err=%0d expected 0 0", riseViol, lenViol);
    end
    testsRun++;
    if (gapViol != 0) begin failCount++; $display("[TB] FAIL timing_gap: got %0d short gaps expected 0", gapViol); end
    testsRun++;
    if (framesSeen < 10) begin failCount++; $display("[TB] FAIL timing_frames_seen: got %0d expected >= 10", framesSeen); end
  endtask

  // Scenario sequence; each task drives its own stimulus and checks inline.
  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_random();
    test_valid_drop();
    test_reset_mid_frame();
    test_wrap();
    test_half_per_one();
    test_timing();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
